microseq_dispatch: RTL and testbench
====================================

Name: microseq_dispatch

Overview:
- Parametrised microcoded sequencer. Each microcode word selects how the current state advances: increment, dispatch-table branch on the input vector, absolute jump, return to 0, or hold.
- Advances on either of two triggers: the sampled input `Y` changes, or `Y` stays stable for HOLD_CNT+1 cycles (timeout step).
- Microcode and dispatch tables are runtime-writable through a config port.
- Sits between debounced board inputs and the display/LED logic, and supersedes the fixed-ROM sequencer.

Parameters:
- IN_W, 2, width of input `Y`; each dispatch table has 2^IN_W entries.
- STATE_W, 4, width of the state / microcode address.
- DEPTH, 13, number of microcode words, 2 ≤ DEPTH ≤ 2^STATE_W.
- N_DISP, 2, number of dispatch tables, 1..4.
- HOLD_CNT, 100000000, stable-input cycles before a timeout step; 32-bit compare.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  sequencer enable
- Y  in  IN_W  branch-condition input
- cfg_we  in  1  config write strobe
- cfg_sel  in  3  0 = microcode; k = dispatch table k-1 (k = 1..N_DISP)
- cfg_addr  in  STATE_W  entry address
- cfg_data  in  3+STATE_W  microcode: {op[2:0], target}; dispatch: low STATE_W bits only
- state  out  STATE_W  current state
- step  out  1  one-cycle pulse, high in the cycle after `state` updates
- op_o  out  3  opcode executed on the last step

Behaviour:
- **Reset (async, rst_n=0):**
  - Outputs and internal registers: `state`=0, `step`=0, `op_o`=0, counter=0, `last_y`=0, primed=0.
  - All microcode words = 0 (NEXT). All dispatch entries = 0.
  - Reset asserted mid-operation aborts the pending step and discards earlier config writes.
- **Opcodes:**
  - 0 NEXT: state+1; wraps to 0 after DEPTH-1.
  - 1..4 DISPk: `dtab[k-1][y_used]`, where y_used is the input value selecting the branch (defined under triggers).
  - 5 JUMP: target field.
  - 6 ZERO: 0.
  - 7 HOLD: state unchanged; still counts as a step.
  - DISPk with k > N_DISP acts as HOLD.
- **Range rules:** any computed next state ≥ DEPTH becomes 0. If `state` ≥ DEPTH, the op is treated as ZERO.
- **Per-cycle flow, en=1:**
  - primed=0: `last_y`←Y, primed←1, no step. This prevents a spurious change-step after reset.
  - Change trigger, primed=1 and Y≠last_y: step with y_used=Y; counter←0; `last_y`←Y.
  - Timeout trigger, primed=1, Y==last_y, counter==HOLD_CNT: step with y_used=`last_y`; counter←0.
  - Otherwise: counter←counter+1.
  - Change has priority over timeout in the same cycle.
  - With stable Y, a step occurs every HOLD_CNT+1 cycles.
- **en=0:** no steps; counter←0; `last_y` keeps tracking Y; primed unchanged.
- **Step timing:** `state` and `op_o` update on the triggering edge; `step`=1 for exactly that following cycle, otherwise 0.
- **Config writes:**
  - A write is committed on the edge where cfg_we=1.
  - A step on the same edge uses the pre-write contents.
  - cfg_addr ≥ DEPTH (microcode) or ≥ 2^IN_W (dispatch) is ignored.
  - cfg_sel > N_DISP is ignored.
  - Writes are permitted while en=1.
- **Counter:** 32-bit; never exceeds HOLD_CNT.

Test Plan (all tests use HOLD_CNT=5, defaults otherwise):
- **Reset/prime:** rst_n low → `state`=0, `step`=0; release with Y=2, en=1 → no step on the first cycle; with Y stable, the first step comes 7 cycles after release; `state`=1, `op_o`=0.
- **Timeout wrap:** microcode all NEXT, Y constant → `state` goes 0,1,…,12,0, one `step` pulse every 6 cycles.
- **Dispatch on change:**
  - Setup: write microcode[3]={1,0}; dtab0={4,5,6,6}; reach `state` 3.
  - Stimulus: toggle Y 0→1.
  - Required: next edge gives `state`=5, `step`=1, counter restarts (next timeout 6 cycles later).
- **Jump/zero/hold and range:**
  - microcode[4]={5,7} → `state` 7.
  - microcode[7]={6,x} → `state` 0.
  - op 7 keeps `state` with `step` pulsing.
  - dtab entry 14 → `state` 0.
- **Simultaneous:** cfg write to microcode[`state`] on the same edge as a change trigger → old op is executed; the new op is used on the following step.
- **Enable and reset mid-run:**
  - en=0 for 20 cycles while Y toggles → no step, `state` frozen.
  - Re-enable → first step 6 cycles later.
  - Assert rst_n mid-count → `state`=0 immediately, table contents cleared.

Source files
------------

// File: rtl/microseq_dispatch.sv
// rtl/microseq_dispatch.sv - microcoded sequencer with runtime-writable microcode and dispatch tables
module microseq_dispatch #(
  parameter int          IN_W     = 2,
  parameter int          STATE_W  = 4,
  parameter int          DEPTH    = 13,
  parameter int          N_DISP   = 2,
  parameter int unsigned HOLD_CNT = 100000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [IN_W-1:0]    Y,
  input  logic               cfg_we,
  input  logic [2:0]         cfg_sel,
  input  logic [STATE_W-1:0] cfg_addr,
  input  logic [STATE_W+2:0] cfg_data,
  output logic [STATE_W-1:0] state,
  output logic               step,
  output logic [2:0]         op_o
);

  localparam int N_ENT = 1 << IN_W;

  localparam logic [2:0] OP_NEXT = 3'd0;
  localparam logic [2:0] OP_JUMP = 3'd5;
  localparam logic [2:0] OP_ZERO = 3'd6;
  localparam logic [2:0] OP_HOLD = 3'd7;

  // Microcode word = {op[2:0], target[STATE_W-1:0]}
  logic [STATE_W+2:0] ucode [DEPTH];
  logic [STATE_W-1:0] dtab  [N_DISP][N_ENT];

  logic [31:0]        counter;
  logic [IN_W-1:0]    last_y;
  logic               primed;

  logic               in_range;
  logic [STATE_W+2:0] cur_word;
  logic [2:0]         cur_op;
  logic [STATE_W-1:0] cur_tgt;
  logic               change_trig;
  logic               timeout_trig;
  logic               do_step;
  logic [IN_W-1:0]    y_used;
  logic [STATE_W-1:0] raw_next;
  logic [STATE_W-1:0] next_state;

  // Trigger detection: an input change wins over a timeout in the same cycle
  always_comb begin
    change_trig  = en && primed && (Y != last_y);
    timeout_trig = en && primed && (Y == last_y) && (counter == HOLD_CNT);
    do_step      = change_trig || timeout_trig;
    y_used       = change_trig ? Y : last_y;
  end

  // Fetch the current microcode word; a state outside the table behaves as ZERO
  always_comb begin
    cur_word = '0;
    in_range = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (32'(state) == i) begin
        cur_word = ucode[i];
        in_range = 1'b1;
      end
    end
    cur_op  = in_range ? cur_word[STATE_W+2:STATE_W] : OP_ZERO;
    cur_tgt = cur_word[STATE_W-1:0];
  end

  // Next-state selection; anything landing past the last word folds back to 0
  always_comb begin
    raw_next = state;
    case (cur_op)
      OP_NEXT: raw_next = state + STATE_W'(1);
      OP_JUMP: raw_next = cur_tgt;
      OP_ZERO: raw_next = '0;
      OP_HOLD: raw_next = state;
      default: begin
        // Dispatch ops naming a table that does not exist fall through as HOLD
        raw_next = state;
        for (int k = 0; k < N_DISP; k++) begin
          if (32'(cur_op) == k + 1) raw_next = dtab[k][y_used];
        end
      end
    endcase
    next_state = (32'(raw_next) >= DEPTH) ? '0 : raw_next;
  end

  // Sequencer state, step pulse, input tracking and stable-input counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= '0;
      step    <= 1'b0;
      op_o    <= '0;
      counter <= '0;
      last_y  <= '0;
      primed  <= 1'b0;
    end else begin
      step <= do_step;
      if (do_step) begin
        state <= next_state;
        op_o  <= cur_op;
      end
      if (!en) begin
        counter <= '0;
        last_y  <= Y;
      end else if (!primed) begin
        // First enabled cycle only captures Y so reset cannot look like a change
        primed <= 1'b1;
        last_y <= Y;
      end else if (do_step) begin
        counter <= '0;
        last_y  <= Y;
      end else begin
        counter <= counter + 32'd1;
      end
    end
  end

  // Table writes; a step on the same edge has already read the old contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ucode[i] <= '0;
      for (int k = 0; k < N_DISP; k++) begin
        for (int j = 0; j < N_ENT; j++) dtab[k][j] <= '0;
      end
    end else if (cfg_we) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cfg_sel == 3'd0 && 32'(cfg_addr) == i) ucode[i] <= cfg_data;
      end
      for (int k = 0; k < N_DISP; k++) begin
        if (32'(cfg_sel) == k + 1 && 32'(cfg_addr) < N_ENT)
          dtab[k][cfg_addr[IN_W-1:0]] <= cfg_data[STATE_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_microseq_dispatch.sv
// tb/tb_microseq_dispatch.sv - randomized and directed bench for microseq_dispatch
module tb_microseq_dispatch;

  localparam int IN_W    = 2;
  localparam int STATE_W = 4;
  localparam int DEPTH   = 13;
  localparam int N_DISP  = 2;
  localparam int HOLD    = 5;
  localparam int MASK    = (1 << STATE_W) - 1;
  localparam int N_ENT   = 1 << IN_W;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               en = 1'b0;
  logic [IN_W-1:0]    Y = '0;
  logic               cfg_we = 1'b0;
  logic [2:0]         cfg_sel = '0;
  logic [STATE_W-1:0] cfg_addr = '0;
  logic [STATE_W+2:0] cfg_data = '0;
  logic [STATE_W-1:0] state;
  logic               step;
  logic [2:0]         op_o;

  int errors = 0;
  int checks = 0;

  // Reference model
  int m_ucode [DEPTH];
  int m_dtab  [N_DISP][N_ENT];
  int m_state, m_op, m_step, m_prev_y, m_quiet;
  bit m_primed;

  microseq_dispatch #(
    .IN_W(IN_W), .STATE_W(STATE_W), .DEPTH(DEPTH), .N_DISP(N_DISP), .HOLD_CNT(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .Y(Y),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .state(state), .step(step), .op_o(op_o)
  );

  always #5 clk = ~clk;

  task automatic m_clear();
    for (int i = 0; i < DEPTH; i++) m_ucode[i] = 0;
    for (int k = 0; k < N_DISP; k++)
      for (int j = 0; j < N_ENT; j++) m_dtab[k][j] = 0;
    m_state = 0; m_op = 0; m_step = 0; m_prev_y = 0; m_quiet = 0; m_primed = 0;
  endtask

  task automatic m_fire(input int yu);
    int op, tgt, n;
    if (m_state >= DEPTH) begin
      op = 6; tgt = 0;
    end else begin
      op  = m_ucode[m_state] >> STATE_W;
      tgt = m_ucode[m_state] & MASK;
    end
    case (op)
      0:       n = m_state + 1;
      5:       n = tgt;
      6:       n = 0;
      7:       n = m_state;
      default: n = (op <= N_DISP) ? m_dtab[op-1][yu] : m_state;
    endcase
    if (n >= DEPTH) n = 0;
    m_state = n;
    m_op    = op;
    m_step  = 1;
  endtask

  // One clock: inputs sampled as they stand, model advanced at the edge
  task automatic cycle();
    int y_s, sel_s, addr_s, data_s;
    bit en_s, we_s;
    en_s = en; y_s = int'(Y); we_s = cfg_we;
    sel_s = int'(cfg_sel); addr_s = int'(cfg_addr); data_s = int'(cfg_data);
    @(posedge clk);
    m_step = 0;
    if (rst_n) begin
      if (!en_s) m_quiet = 0;
      else if (!m_primed) m_primed = 1;
      else if (y_s != m_prev_y) begin
        m_fire(y_s);
        m_quiet = 0;
      end else begin
        m_quiet++;
        if (m_quiet == HOLD + 1) begin
          m_fire(m_prev_y);
          m_quiet = 0;
        end
      end
      m_prev_y = y_s;
      if (we_s) begin
        if (sel_s == 0 && addr_s < DEPTH) m_ucode[addr_s] = data_s;
        else if (sel_s >= 1 && sel_s <= N_DISP && addr_s < N_ENT) m_dtab[sel_s-1][addr_s] = data_s & MASK;
      end
    end
    #2;
  endtask

  task automatic cfg_write(input int sel, input int addr, input int data);
    cfg_we = 1'b1; cfg_sel = 3'(sel); cfg_addr = STATE_W'(addr); cfg_data = (STATE_W+3)'(data);
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic run_until_step(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      cycle();
      if (step === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; cfg_we = 1'b0;
    m_clear();
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0; en = 1'b0;
    m_clear();
    @(posedge clk); #2;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL reset_step: got %0d expected 0", step); end
    checks++; if (op_o !== 3'd0) begin errors++; $display("FAIL reset_op: got %0d expected 0", op_o); end
    Y = 2'd2; en = 1'b1; rst_n = 1'b1;
    cycle();
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL prime_no_step: got %0d expected 0", step); end
    run_until_step(20, n);
    checks++; if (n + 1 != 7) begin errors++; $display("FAIL prime_first_step_cycles: got %0d expected 7", n + 1); end
    checks++; if (state !== 4'd1) begin errors++; $display("FAIL prime_state: got %0d expected 1", state); end
    checks++; if (op_o !== 3'd0) begin errors++; $display("FAIL prime_op: got %0d expected 0", op_o); end
  endtask

  task automatic test_timeout_wrap();
    int n;
    do_reset();
    Y = 2'd1; en = 1'b1;
    run_until_step(20, n);
    checks++; if (state !== 4'd1) begin errors++; $display("FAIL wrap_first: got %0d expected 1", state); end
    for (int k = 2; k <= 13; k++) begin
      run_until_step(20, n);
      checks++; if (n != 6) begin errors++; $display("FAIL wrap_period k=%0d: got %0d expected 6", k, n); end
      checks++; if (state !== 4'(k % 13)) begin errors++; $display("FAIL wrap_state k=%0d: got %0d expected %0d", k, state, k % 13); end
    end
  endtask

  task automatic test_dispatch_change();
    int n;
    do_reset();
    cfg_write(0, 3, 7'h10);
    cfg_write(1, 0, 4); cfg_write(1, 1, 5); cfg_write(1, 2, 6); cfg_write(1, 3, 6);
    Y = 2'd0; en = 1'b1;
    for (int s = 0; s < 3; s++) run_until_step(20, n);
    checks++; if (state !== 4'd3) begin errors++; $display("FAIL disp_reach3: got %0d expected 3", state); end
    Y = 2'd1;
    cycle();
    checks++; if (state !== 4'd5) begin errors++; $display("FAIL disp_state: got %0d expected 5", state); end
    checks++; if (step !== 1'b1) begin errors++; $display("FAIL disp_step: got %0d expected 1", step); end
    checks++; if (op_o !== 3'd1) begin errors++; $display("FAIL disp_op: got %0d expected 1", op_o); end
    run_until_step(20, n);
    checks++; if (n != 6) begin errors++; $display("FAIL disp_restart: got %0d expected 6", n); end
    checks++; if (state !== 4'd6) begin errors++; $display("FAIL disp_after: got %0d expected 6", state); end
  endtask

  task automatic test_jump_zero_hold();
    int n;
    do_reset();
    cfg_write(0, 4, 7'h57);
    cfg_write(0, 7, 7'h63);
    cfg_write(2, 2, 14);
    Y = 2'd2; en = 1'b1;
    for (int s = 0; s < 5; s++) run_until_step(20, n);
    checks++; if (state !== 4'd7 || op_o !== 3'd5) begin errors++; $display("FAIL jump: got state %0d op %0d expected state 7 op 5", state, op_o); end
    run_until_step(20, n);
    checks++; if (state !== 4'd0 || op_o !== 3'd6) begin errors++; $display("FAIL zero: got state %0d op %0d expected state 0 op 6", state, op_o); end
    cfg_write(0, 0, 7'h70);
    run_until_step(20, n);
    checks++; if (state !== 4'd0 || op_o !== 3'd7) begin errors++; $display("FAIL hold1: got state %0d op %0d expected state 0 op 7", state, op_o); end
    run_until_step(20, n);
    checks++; if (n != 6 || state !== 4'd0) begin errors++; $display("FAIL hold2: got period %0d state %0d expected 6 and 0", n, state); end
    cfg_write(0, 0, 7'h00);
    cfg_write(0, 1, 7'h20);
    run_until_step(20, n);
    checks++; if (state !== 4'd1) begin errors++; $display("FAIL range_pre: got %0d expected 1", state); end
    run_until_step(20, n);
    checks++; if (state !== 4'd0 || op_o !== 3'd2) begin errors++; $display("FAIL range_fold: got state %0d op %0d expected state 0 op 2", state, op_o); end
  endtask

  task automatic test_simultaneous();
    int n;
    do_reset();
    cfg_write(0, 2, 7'h70);
    Y = 2'd0; en = 1'b1;
    for (int s = 0; s < 2; s++) run_until_step(20, n);
    checks++; if (state !== 4'd2) begin errors++; $display("FAIL simul_reach2: got %0d expected 2", state); end
    Y = 2'd1;
    cfg_we = 1'b1; cfg_sel = 3'd0; cfg_addr = 4'd2; cfg_data = 7'h59;
    cycle();
    cfg_we = 1'b0;
    checks++; if (state !== 4'd2 || op_o !== 3'd7 || step !== 1'b1) begin errors++; $display("FAIL simul_old_op: got state %0d op %0d step %0d expected 2 7 1", state, op_o, step); end
    run_until_step(20, n);
    checks++; if (n != 6 || state !== 4'd9 || op_o !== 3'd5) begin errors++; $display("FAIL simul_new_op: got period %0d state %0d op %0d expected 6 9 5", n, state, op_o); end
  endtask

  task automatic test_enable_reset();
    int n, bad;
    do_reset();
    cfg_write(0, 1, 7'h5B);
    Y = 2'd3; en = 1'b1;
    run_until_step(20, n);
    checks++; if (state !== 4'd1) begin errors++; $display("FAIL en_pre: got %0d expected 1", state); end
    en = 1'b0; bad = 0;
    for (int i = 0; i < 20; i++) begin
      Y = Y + 2'd1;
      cycle();
      if (step !== 1'b0 || state !== 4'd1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL en_frozen: got %0d bad cycles expected 0", bad); end
    en = 1'b1;
    run_until_step(20, n);
    checks++; if (n != 6 || state !== 4'd11) begin errors++; $display("FAIL en_resume: got period %0d state %0d expected 6 11", n, state); end
    cycle(); cycle();
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (state !== 4'd0 || step !== 1'b0 || op_o !== 3'd0) begin errors++; $display("FAIL midrun_reset: got state %0d step %0d op %0d expected 0 0 0", state, step, op_o); end
    m_clear();
    @(posedge clk); #2;
    rst_n = 1'b1; Y = 2'd3; en = 1'b1;
    run_until_step(20, n);
    checks++; if (n != 7 || state !== 4'd1) begin errors++; $display("FAIL post_reset_first: got period %0d state %0d expected 7 1", n, state); end
    run_until_step(20, n);
    checks++; if (state !== 4'd2 || op_o !== 3'd0) begin errors++; $display("FAIL table_cleared: got state %0d op %0d expected 2 0", state, op_o); end
  endtask

  task automatic test_random();
    do_reset();
    Y = 2'd0;
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 5) == 0) Y = IN_W'($urandom_range(0, N_ENT - 1));
      cfg_we = ($urandom_range(0, 3) == 0);
      cfg_sel = 3'($urandom_range(0, 7) < 4 ? 0 : $urandom_range(0, 7));
      cfg_addr = STATE_W'($urandom_range(0, MASK));
      cfg_data = (STATE_W+3)'($urandom_range(0, 127));
      cycle();
      checks++; if (state !== 4'(m_state)) begin errors++; $display("FAIL rand_state cyc=%0d: got %0d expected %0d", i, state, m_state); end
      checks++; if (step !== 1'(m_step)) begin errors++; $display("FAIL rand_step cyc=%0d: got %0d expected %0d", i, step, m_step); end
      checks++; if (op_o !== 3'(m_op)) begin errors++; $display("FAIL rand_op cyc=%0d: got %0d expected %0d", i, op_o, m_op); end
    end
    cfg_we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_timeout_wrap();
    test_dispatch_change();
    test_jump_zero_hold();
    test_simultaneous();
    test_enable_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
